// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the iterative ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOR = 3'b100,
    OP_NOT = 3'b101,
    OP_ROL = 3'b110,
    OP_ROR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Rotates are the only multi-cycle ops.
  function automatic logic is_rotate(input alu_op_e op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops with zero/carry/overflow flags. Rotate codes pass b
// through unchanged, which is the correct result for a rotate by zero.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;

  // Shared adder (SUB is a + ~b + 1), op select and flag generation.
  always_comb begin
    b_eff    = (op == OP_SUB) ? ~b : b;
    cin      = (op == OP_SUB);
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    result   = b;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_NOT:  result = ~a;
      default: result = b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle ops finish in one cycle, rotates step one bit
// per cycle. Result and flags are held in DONE until the consumer takes them.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit EARLY_ACCEPT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e         state, state_nxt;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic               rot_left;
  logic [SHAMT_W-1:0] n;
  logic               rot_op;
  logic               accept;
  logic               multi_cycle;
  logic               rot_last;
  logic [WIDTH-1:0]   first_rot;
  logic [WIDTH-1:0]   step_rot;
  logic [WIDTH-1:0]   c_result;
  logic               c_zero, c_carry, c_overflow;

  // One-bit rotate in either direction.
  function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] v, input logic left);
    return left ? {v[WIDTH-2:0], v[WIDTH-1]} : {v[0], v[WIDTH-1:1]};
  endfunction

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (c_result),
    .zero     (c_zero),
    .carry    (c_carry),
    .overflow (c_overflow)
  );

  assign n           = a[SHAMT_W-1:0];
  assign rot_op      = is_rotate(op);
  assign multi_cycle = rot_op && (n > SHAMT_W'(1));
  assign first_rot   = rot1(b, op == OP_ROL);
  assign step_rot    = rot1(work, rot_left);
  assign rot_last    = (state == ROT) && (cnt == SHAMT_W'(1));

  // in_ready is forced low while reset is asserted, even though state reads IDLE.
  assign in_ready  = !reset && ((state == IDLE) ||
                                (EARLY_ACCEPT && (state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an accept from DONE only happens when out_ready is high.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = multi_cycle ? ROT : DONE;
      ROT:  if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? (multi_cycle ? ROT : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: loaded at accept (single-cycle or n<=1 rotate) or on the last rotate step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (!rot_op || (n == '0)) begin
        result   <= c_result;
        zero     <= c_zero;
        carry    <= c_carry;
        overflow <= c_overflow;
      end else if (n == SHAMT_W'(1)) begin
        result   <= first_rot;
        zero     <= (first_rot == '0);
        carry    <= 1'b0;
        overflow <= 1'b0;
      end
    end else if (rot_last) begin
      result   <= step_rot;
      zero     <= (step_rot == '0);
      carry    <= 1'b0;
      overflow <= 1'b0;
    end
  end

  // Rotate work register and remaining-step counter (don't-care outside ROT).
  always_ff @(posedge clk) begin
    if (accept) begin
      work     <= first_rot;
      cnt      <= n - SHAMT_W'(1);
      rot_left <= (op == OP_ROL);
    end else if (state == ROT) begin
      work <= step_rot;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule
